// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and width defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  // Bits needed to hold a streak count of 0..max_streak.
  function automatic int streak_width(input int max_streak);
    return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational grant selection: cpu first, unless dbg has waited out a full streak.
module arb_priority_sel
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int SW         = 3
) (
  input  logic          cpu_req,
  input  logic          dbg_req,
  input  logic [SW-1:0] streak,
  output logic          grant_valid,
  output logic          grant_owner
);

  logic streak_full;

  assign streak_full = (streak == SW'(MAX_STREAK));

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_CPU;
    if (cpu_req && !(dbg_req && streak_full)) begin
      grant_valid = 1'b1;
    end else if (dbg_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sequencing fixed-latency accesses to a single-ported data memory.
// state    | meaning
// ARB_IDLE | no access in flight; arbitrate pending requests
// ARB_BUSY | memory access active for LATENCY cycles
// ARB_RESP | owner's done pulse with rdata valid
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_LEN,
  parameter int DATA_W     = DATA_LEN,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int SW = streak_width(MAX_STREAK);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(LATENCY - 2);
  // With a single-cycle access the write strobe must already be up in the grant's next cycle.
  localparam logic WE_AT_GRANT = (LATENCY == 1);

  arb_state_e        state_q;
  logic              owner_q;
  logic [CW-1:0]     count_q;
  logic [SW-1:0]     streak_q;
  logic [SW-1:0]     streak_d;
  logic              we_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              cpu_done_q;
  logic              dbg_done_q;

  logic              grant_valid;
  logic              grant_owner;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  arb_priority_sel #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_sel (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .streak      (streak_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign mem_we_d    = (grant_owner == OWNER_DBG) ? dbg_we    : cpu_we;
  assign mem_addr_d  = (grant_owner == OWNER_DBG) ? dbg_addr  : cpu_addr;
  assign mem_wdata_d = (grant_owner == OWNER_DBG) ? dbg_wdata : cpu_wdata;

  always_comb begin
    streak_d = streak_q;
    if (!dbg_req || (grant_owner == OWNER_DBG)) begin
      streak_d = '0;
    end else if (streak_q != SW'(MAX_STREAK)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_CPU;
      count_q     <= '0;
      streak_q    <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_valid) begin
            state_q     <= ARB_BUSY;
            owner_q     <= grant_owner;
            count_q     <= '0;
            streak_q    <= streak_d;
            we_q        <= mem_we_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= WE_AT_GRANT & mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
          end
        end
        ARB_BUSY: begin
          if (count_q == CNT_LAST) begin
            state_q  <= ARB_RESP;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_q == OWNER_DBG) begin
              dbg_done_q <= 1'b1;
              if (!we_q) dbg_rdata_q <= mem_rdata;
            end else begin
              cpu_done_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= mem_rdata;
            end
          end else begin
            count_q  <= count_q + 1'b1;
            mem_we_q <= we_q & (count_q == CNT_PRE);
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_stall = cpu_req & ~cpu_done_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_done  = dbg_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ARB_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a LATENCY=2 instance for most cases, a LATENCY=1 instance for back-to-back reads.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_done, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_done;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          b_cpu_req, b_cpu_done, b_cpu_stall, b_dbg_done;
  logic [AW-1:0] b_cpu_addr, b_mem_addr;
  logic [DW-1:0] b_cpu_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_mem_en, b_mem_we, b_busy, b_owner;

  // Memory model for the LATENCY=1 instance: data derived from the address.
  assign b_mem_rdata = 32'h5A00_0000 | b_mem_addr;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2), .MAX_STREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .MAX_STREAK(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(b_cpu_addr), .cpu_wdata(32'h0),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
    .dbg_rdata(b_dbg_rdata), .dbg_done(b_dbg_done),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int            t_cyc, t_en, t_we, t_we_at, t_ovl, t_stall;
  logic [AW-1:0] t_we_addr;
  logic [DW-1:0] t_we_data;

  // sel: 0 cpu done, 1 dbg done, 2 LATENCY=1 cpu done, 3 either done on the main instance
  task automatic wait_done(input int sel);
    logic d;
    d = 1'b0;
    t_cyc = 0; t_en = 0; t_we = 0; t_we_at = 0; t_ovl = 0; t_stall = 0;
    t_we_addr = '0; t_we_data = '0;
    while (!d && t_cyc < 20) begin
      step(1);
      t_cyc++;
      if (sel == 2) begin
        if (b_mem_en) t_en++;
        if (b_mem_we) t_we++;
        d = b_cpu_done;
      end else begin
        if (mem_en) t_en++;
        if (cpu_stall) t_stall++;
        if (mem_we) begin
          t_we++; t_we_at = t_cyc; t_we_addr = mem_addr; t_we_data = mem_wdata;
        end
        if (cpu_done && dbg_done) t_ovl++;
        case (sel)
          0:       d = cpu_done;
          1:       d = dbg_done;
          default: d = cpu_done | dbg_done;
        endcase
      end
    end
    check_val("done_within_budget", {63'd0, d}, 64'd1);
  endtask

  logic [9:0] seq;
  int         bad_gap, ovl_sum, rst_we, rst_done;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0; b_cpu_req = 0; b_cpu_addr = '0;

    // Reset state
    #12;
    check_val("rst_flags", {57'd0, busy, mem_en, mem_we, cpu_done, dbg_done, owner, cpu_stall}, 64'd0);
    check_val("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check_val("rst_rdata", {cpu_rdata, dbg_rdata}, 64'd0);
    cpu_req = 1; #1;
    check_val("rst_stall_follows_req", {63'd0, cpu_stall}, 64'd1);
    cpu_req = 0;
    step(2);
    rst = 1'b1;
    step(1);
    check_val("idle_no_req", {62'd0, busy, mem_en}, 64'd0);

    // 1: cpu read
    mem_rdata = 32'hDEAD_BEEF; cpu_addr = 32'h10; cpu_we = 0; cpu_req = 1; #1;
    check_val("t1_stall_at_req", {63'd0, cpu_stall}, 64'd1);
    wait_done(0);
    check_val("t1_latency", t_cyc, 3);
    check_val("t1_mem_en_cycles", t_en, 2);
    check_val("t1_no_write", t_we, 0);
    check_val("t1_stall_cycles", t_stall, 2);
    check_val("t1_rdata", {32'd0, cpu_rdata}, 64'hDEAD_BEEF);
    check_val("t1_stall_at_done", {63'd0, cpu_stall}, 64'd0);
    cpu_req = 0;
    step(1);
    check_val("t1_done_one_cycle", {63'd0, cpu_done}, 64'd0);
    step(1);

    // 2: dbg write
    mem_rdata = 32'hCAFE_F00D; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678; dbg_req = 1;
    wait_done(1);
    check_val("t2_latency", t_cyc, 3);
    check_val("t2_we_pulses", t_we, 1);
    check_val("t2_we_cycle", t_we_at, 2);
    check_val("t2_we_addr", {32'd0, t_we_addr}, 64'h20);
    check_val("t2_we_data", {32'd0, t_we_data}, 64'h1234_5678);
    check_val("t2_dbg_rdata_kept", {32'd0, dbg_rdata}, 64'd0);
    check_val("t2_owner", {63'd0, owner}, 64'd1);
    dbg_req = 0; dbg_we = 0;
    step(2);

    // 3: simultaneous requests
    mem_rdata = 32'h1111_1111; cpu_addr = 32'h30; dbg_addr = 32'h40; cpu_req = 1; dbg_req = 1;
    wait_done(0);
    check_val("t3_cpu_first_latency", t_cyc, 3);
    check_val("t3_cpu_owner", {63'd0, owner}, 64'd0);
    check_val("t3_no_overlap_a", t_ovl, 0);
    cpu_req = 0; mem_rdata = 32'h2222_2222;
    wait_done(1);
    check_val("t3_dbg_gap", t_cyc, 4);
    check_val("t3_dbg_owner", {63'd0, owner}, 64'd1);
    check_val("t3_dbg_rdata", {32'd0, dbg_rdata}, 64'h2222_2222);
    check_val("t3_cpu_rdata_kept", {32'd0, cpu_rdata}, 64'h1111_1111);
    check_val("t3_no_overlap_b", t_ovl, 0);
    dbg_req = 0;
    step(2);

    // 4: streak limit with both held
    mem_rdata = 32'h3333_3333; cpu_req = 1; dbg_req = 1;
    seq = '0; bad_gap = 0; ovl_sum = 0;
    for (int i = 0; i < 10; i++) begin
      wait_done(3);
      seq[i] = dbg_done;
      ovl_sum += t_ovl;
      if (t_cyc != ((i == 0) ? 3 : 4)) bad_gap++;
    end
    cpu_req = 0; dbg_req = 0;
    check_val("t4_owner_sequence", {54'd0, seq}, 64'h210);
    check_val("t4_spacing_errors", bad_gap, 0);
    check_val("t4_no_overlap", ovl_sum, 0);
    check_val("t4_rdata_both", {cpu_rdata, dbg_rdata}, 64'h3333_3333_3333_3333);
    step(2);

    // 5: reset during first BUSY cycle of a cpu write
    cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'hAA55_AA55; cpu_req = 1;
    step(1);
    check_val("t5_busy_before_rst", {62'd0, busy, mem_en}, 64'd3);
    rst = 1'b0; #1;
    check_val("t5_rst_flags", {58'd0, busy, mem_en, mem_we, cpu_done, dbg_done, owner}, 64'd0);
    check_val("t5_rst_addr_rdata", {mem_addr, cpu_rdata}, 64'd0);
    check_val("t5_stall_in_rst", {63'd0, cpu_stall}, 64'd1);
    rst_we = 0; rst_done = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (mem_we) rst_we++;
      if (cpu_done || dbg_done) rst_done++;
    end
    check_val("t5_no_we_no_done", {rst_we[31:0], rst_done[31:0]}, 64'd0);
    rst = 1'b1;
    wait_done(0);
    check_val("t5_restart_latency", t_cyc, 3);
    check_val("t5_restart_we", {t_we[31:0], t_we_at[31:0]}, {32'd1, 32'd2});
    check_val("t5_restart_addr", {32'd0, t_we_addr}, 64'h50);
    check_val("t5_write_keeps_rdata", {32'd0, cpu_rdata}, 64'd0);
    cpu_req = 0; cpu_we = 0;
    step(2);

    // 6: LATENCY=1 back-to-back cpu reads
    b_cpu_addr = 32'h0; b_cpu_req = 1;
    wait_done(2);
    check_val("t6_first_latency", t_cyc, 2);
    check_val("t6_first_en", t_en, 1);
    check_val("t6_first_rdata", {32'd0, b_cpu_rdata}, 64'h5A00_0000);
    b_cpu_addr = 32'h4;
    wait_done(2);
    check_val("t6_done_spacing", t_cyc, 3);
    check_val("t6_second_rdata", {32'd0, b_cpu_rdata}, 64'h5A00_0004);
    check_val("t6_no_write", t_we, 0);
    b_cpu_req = 0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
